reorder_buffer: RTL and testbench
=================================

# reorder_buffer

Circular reorder buffer sitting between the dispatcher, the common data bus (CDB) and the register file. It allocates one entry per dispatched instruction and captures results broadcast on the CDB. It retires entries strictly in program order, driving the RoBRF commit interface the register file consumes. On a mispredicted branch reaching the head, it signals the flush (`RoBRF_pre_judge` low), redirects fetch and empties itself.

## Interface
Parameters:
- RoB_WIDTH, 8, index width; RoB_SIZE = 1 << RoB_WIDTH entries
- EX_REG_WIDTH, 6, register field width; NON_REG = 6'b100000 means no destination

Ports:
- Sys_clk  in  1  clock; single clock domain
- Sys_rst  in  1  synchronous, active-high reset
- Sys_rdy  in  1  global enable; when low all state holds
- DPRoB_en  in  1  allocate one entry this cycle
- DPRoB_rd  in  EX_REG_WIDTH  destination, NON_REG if none
- DPRoB_is_branch  in  1  conditional branch entry (rd is always NON_REG)
- DPRoB_pred  in  1  predicted taken
- RoBDP_full  out  1  no free entry (combinational from count)
- RoBDP_index  out  RoB_WIDTH  index the next allocation receives (= tail)
- DPRoB_qidx1, DPRoB_qidx2  in  RoB_WIDTH  operand lookup indices
- RoBDP_rdy1, RoBDP_rdy2  out  1  looked-up entry has its result (combinational)
- RoBDP_val1, RoBDP_val2  out  32  looked-up value; 0 when not ready
- CDBRoB_en  in  1  result broadcast valid
- CDBRoB_index  in  RoB_WIDTH  entry being completed
- CDBRoB_value  in  32  result value
- CDBRoB_taken  in  1  actual branch outcome (branch entries)
- CDBRoB_target  in  32  correct next PC when a branch resolves
- RoBRF_en  out  1  commit pulse carrying a destination write
- RoBRF_RoB_index  out  RoB_WIDTH  committed entry index
- RoBRF_rd  out  EX_REG_WIDTH  committed destination
- RoBRF_value  out  32  committed value
- RoBRF_pre_judge  out  1  0 for one cycle on mispredict commit, else 1
- RoBIF_jump_en  out  1  fetch redirect pulse
- RoBIF_pc  out  32  redirect target

## Operation
- Per-entry storage: busy, ready, rd, value, is_branch, pred, taken, target.
- State: head, tail (RoB_WIDTH each, wrap naturally modulo RoB_SIZE) and count (RoB_WIDTH+1 bits, 0..RoB_SIZE).
- Allocate: on DPRoB_en && !RoBDP_full, write entry[tail] with busy=1 and ready=0, then tail++ and count++. DPRoB_en while full is ignored.
- Complete: on CDBRoB_en, set entry[CDBRoB_index] to ready=1 and latch value, taken and target. A write to a non-busy entry is ignored.
- Commit: if count>0 && entry[head].ready, retire head, clear busy, head++ and count--. At most one commit per cycle.
- Non-branch commit: RoBRF_en = (rd != NON_REG); pre_judge=1.
- Branch commit, correct prediction (pred == taken): RoBRF_en=0 and pre_judge=1.
- Branch commit, mispredict:
  - pre_judge=0, RoBIF_jump_en=1, RoBIF_pc=target.
  - At the same edge, all busy/ready bits are cleared and head=tail=count=0.
- Lookup: rdy/val come from the addressed entry's ready/value. Additionally, a CDB write to the same index in the same cycle forwards (rdy=1, val=CDBRoB_value).
- Sys_rdy low: no allocate, complete or commit. Pulse outputs go to 0 and pre_judge goes to 1 at the next edge.

## Timing
- Reset (synchronous, Sys_rst high at edge): head=tail=count=0, all busy/ready=0. RoBRF_en=0, RoBRF_RoB_index=0, RoBRF_rd=NON_REG, RoBRF_value=0, RoBRF_pre_judge=1, RoBIF_jump_en=0, RoBIF_pc=0. Reset mid-stream discards all entries.
- Commit outputs are registered. They are valid for exactly the one cycle after the retiring edge, and default back the following cycle.
- Latency: with a CDB write at edge T into the head entry, commit happens at edge T+1 and outputs are visible during cycle T+1..T+2. Earliest commit is 2 edges after dispatch.
- RoBDP_full = (count == RoB_SIZE). Allocate in the same cycle as a commit at full is refused; count ends at RoB_SIZE-1.
- Allocate and commit in the same cycle: count unchanged, head and tail both advance.
- Mispredict flush wins over a same-cycle allocate and CDB write; both are dropped.
- A CDB write to the head in a cycle where head is not yet ready does not commit in that cycle.

## Test plan
- Reset, then dispatch rd=5 (gets index 0), CDB index 0 value 0x1234 -> one cycle later RoBRF_en=1, rd=5, RoB_index=0, value=0x1234, pre_judge=1.
- Dispatch A(rd=1) and B(rd=2); CDB completes B before A -> nothing commits until A completes. Then A and B commit on consecutive cycles, in order.
- Dispatch RoB_SIZE entries -> RoBDP_full=1 and a further DPRoB_en is ignored. Complete head -> after commit full=0, and the next allocation gets index 0 again after wrap.
- Dispatch branch pred=0 plus 3 more; CDB taken=1, target=0x80 -> at head commit pre_judge=0, jump_en=1, pc=0x80 for one cycle; next cycle count=0, RoBDP_index=0.
- Correct branch (pred=1, taken=1) -> RoBRF_en=0, pre_judge=1, no jump.
- Lookup DPRoB_qidx1=3 while CDB writes index 3 value 7 -> rdy1=1, val1=7 in the same cycle. Sys_rdy=0 for 5 cycles mid-stream -> no state change.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// rtl/reorder_buffer_if.sv - dispatch, CDB, lookup and commit signals of the reorder buffer
interface reorder_buffer_if #(
  parameter int RoB_WIDTH    = 8,
  parameter int EX_REG_WIDTH = 6
);
  logic                    DPRoB_en;
  logic [EX_REG_WIDTH-1:0] DPRoB_rd;
  logic                    DPRoB_is_branch;
  logic                    DPRoB_pred;
  logic                    RoBDP_full;
  logic [RoB_WIDTH-1:0]    RoBDP_index;
  logic [RoB_WIDTH-1:0]    DPRoB_qidx1;
  logic [RoB_WIDTH-1:0]    DPRoB_qidx2;
  logic                    RoBDP_rdy1;
  logic                    RoBDP_rdy2;
  logic [31:0]             RoBDP_val1;
  logic [31:0]             RoBDP_val2;
  logic                    CDBRoB_en;
  logic [RoB_WIDTH-1:0]    CDBRoB_index;
  logic [31:0]             CDBRoB_value;
  logic                    CDBRoB_taken;
  logic [31:0]             CDBRoB_target;
  logic                    RoBRF_en;
  logic [RoB_WIDTH-1:0]    RoBRF_RoB_index;
  logic [EX_REG_WIDTH-1:0] RoBRF_rd;
  logic [31:0]             RoBRF_value;
  logic                    RoBRF_pre_judge;
  logic                    RoBIF_jump_en;
  logic [31:0]             RoBIF_pc;

  modport master (
    output DPRoB_en, DPRoB_rd, DPRoB_is_branch, DPRoB_pred, DPRoB_qidx1, DPRoB_qidx2,
    output CDBRoB_en, CDBRoB_index, CDBRoB_value, CDBRoB_taken, CDBRoB_target,
    input  RoBDP_full, RoBDP_index, RoBDP_rdy1, RoBDP_rdy2, RoBDP_val1, RoBDP_val2,
    input  RoBRF_en, RoBRF_RoB_index, RoBRF_rd, RoBRF_value, RoBRF_pre_judge,
    input  RoBIF_jump_en, RoBIF_pc
  );

  modport slave (
    input  DPRoB_en, DPRoB_rd, DPRoB_is_branch, DPRoB_pred, DPRoB_qidx1, DPRoB_qidx2,
    input  CDBRoB_en, CDBRoB_index, CDBRoB_value, CDBRoB_taken, CDBRoB_target,
    output RoBDP_full, RoBDP_index, RoBDP_rdy1, RoBDP_rdy2, RoBDP_val1, RoBDP_val2,
    output RoBRF_en, RoBRF_RoB_index, RoBRF_rd, RoBRF_value, RoBRF_pre_judge,
    output RoBIF_jump_en, RoBIF_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular reorder buffer with in-order commit and mispredict flush
module reorder_buffer #(
  parameter int RoB_WIDTH    = 8,
  parameter int EX_REG_WIDTH = 6
) (
  input  logic           Sys_clk,
  input  logic           Sys_rst,
  input  logic           Sys_rdy,
  reorder_buffer_if.slave rob
);
  localparam int RoB_SIZE = 1 << RoB_WIDTH;
  localparam logic [RoB_WIDTH:0]      FULL_CNT = {1'b1, {RoB_WIDTH{1'b0}}};
  localparam logic [EX_REG_WIDTH-1:0] NON_REG  = {1'b1, {(EX_REG_WIDTH-1){1'b0}}};

  logic [RoB_WIDTH-1:0]    head, tail;
  logic [RoB_WIDTH:0]      count;
  logic [RoB_SIZE-1:0]     busy, ready;
  logic [RoB_SIZE-1:0]     is_branch_q, pred_q, taken_q;
  logic [EX_REG_WIDTH-1:0] rd_q     [RoB_SIZE];
  logic [31:0]             value_q  [RoB_SIZE];
  logic [31:0]             target_q [RoB_SIZE];

  logic full, commit_ok, mispredict, alloc_ok, cdb_ok;

  assign full       = (count == FULL_CNT);
  assign commit_ok  = Sys_rdy && (count != '0) && ready[head];
  assign mispredict = commit_ok && is_branch_q[head] && (pred_q[head] != taken_q[head]);
  // A flushing commit drops same-cycle allocate and completion
  assign alloc_ok   = Sys_rdy && rob.DPRoB_en && !full && !mispredict;
  assign cdb_ok     = Sys_rdy && rob.CDBRoB_en && busy[rob.CDBRoB_index] && !mispredict;

  assign rob.RoBDP_full  = full;
  assign rob.RoBDP_index = tail;

  always_ff @(posedge Sys_clk) begin
    if (Sys_rst || mispredict) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
      ready <= '0;
    end else begin
      if (cdb_ok) ready[rob.CDBRoB_index] <= 1'b1;
      if (alloc_ok) begin
        busy[tail]  <= 1'b1;
        ready[tail] <= 1'b0;
        tail        <= tail + 1'b1;
      end
      if (commit_ok) begin
        busy[head] <= 1'b0;
        head       <= head + 1'b1;
      end
      case ({alloc_ok, commit_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset: busy/ready gate every use of it
  always_ff @(posedge Sys_clk) begin
    if (alloc_ok) begin
      rd_q[tail]        <= rob.DPRoB_rd;
      is_branch_q[tail] <= rob.DPRoB_is_branch;
      pred_q[tail]      <= rob.DPRoB_pred;
    end
    if (cdb_ok) begin
      value_q[rob.CDBRoB_index]  <= rob.CDBRoB_value;
      taken_q[rob.CDBRoB_index]  <= rob.CDBRoB_taken;
      target_q[rob.CDBRoB_index] <= rob.CDBRoB_target;
    end
  end

  always_ff @(posedge Sys_clk) begin
    rob.RoBRF_en        <= 1'b0;
    rob.RoBRF_RoB_index <= '0;
    rob.RoBRF_rd        <= NON_REG;
    rob.RoBRF_value     <= '0;
    rob.RoBRF_pre_judge <= 1'b1;
    rob.RoBIF_jump_en   <= 1'b0;
    rob.RoBIF_pc        <= '0;
    if (!Sys_rst && commit_ok) begin
      rob.RoBRF_en        <= !is_branch_q[head] && (rd_q[head] != NON_REG);
      rob.RoBRF_RoB_index <= head;
      rob.RoBRF_rd        <= rd_q[head];
      rob.RoBRF_value     <= value_q[head];
      rob.RoBRF_pre_judge <= !mispredict;
      rob.RoBIF_jump_en   <= mispredict;
      rob.RoBIF_pc        <= mispredict ? target_q[head] : 32'd0;
    end
  end

  // Same-cycle CDB write to the looked-up entry is forwarded
  always_comb begin
    rob.RoBDP_rdy1 = 1'b0;
    rob.RoBDP_val1 = '0;
    rob.RoBDP_rdy2 = 1'b0;
    rob.RoBDP_val2 = '0;
    if (rob.CDBRoB_en && rob.CDBRoB_index == rob.DPRoB_qidx1) begin
      rob.RoBDP_rdy1 = 1'b1;
      rob.RoBDP_val1 = rob.CDBRoB_value;
    end else if (ready[rob.DPRoB_qidx1]) begin
      rob.RoBDP_rdy1 = 1'b1;
      rob.RoBDP_val1 = value_q[rob.DPRoB_qidx1];
    end
    if (rob.CDBRoB_en && rob.CDBRoB_index == rob.DPRoB_qidx2) begin
      rob.RoBDP_rdy2 = 1'b1;
      rob.RoBDP_val2 = rob.CDBRoB_value;
    end else if (ready[rob.DPRoB_qidx2]) begin
      rob.RoBDP_rdy2 = 1'b1;
      rob.RoBDP_val2 = value_q[rob.DPRoB_qidx2];
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed vector bench for reorder_buffer
module tb_reorder_buffer;
  localparam int RW = 8;
  localparam int EW = 6;
  localparam int SZ = 1 << RW;
  localparam int NR = 32;
  localparam int NV = 28;

  logic Sys_clk = 1'b0;
  logic Sys_rst;
  logic Sys_rdy;

  reorder_buffer_if #(.RoB_WIDTH(RW), .EX_REG_WIDTH(EW)) rob ();

  reorder_buffer #(.RoB_WIDTH(RW), .EX_REG_WIDTH(EW)) dut (
    .Sys_clk(Sys_clk),
    .Sys_rst(Sys_rst),
    .Sys_rdy(Sys_rdy),
    .rob    (rob)
  );

  always #5 Sys_clk = ~Sys_clk;

  typedef struct {
    int dp_en, dp_rd, dp_br, dp_pred;
    int c_en, c_idx, c_val, c_tk, c_tgt;
    int e_en, e_idx, e_rd, e_val, e_pj, e_jmp, e_pc, e_tail;
  } vec_t;

  vec_t vt[NV];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rob.DPRoB_en        = 1'b0;
    rob.DPRoB_rd        = '0;
    rob.DPRoB_is_branch = 1'b0;
    rob.DPRoB_pred      = 1'b0;
    rob.DPRoB_qidx1     = '0;
    rob.DPRoB_qidx2     = '0;
    rob.CDBRoB_en       = 1'b0;
    rob.CDBRoB_index    = '0;
    rob.CDBRoB_value    = '0;
    rob.CDBRoB_taken    = 1'b0;
    rob.CDBRoB_target   = '0;
  endtask

  task automatic tick();
    @(posedge Sys_clk);
    #1;
  endtask

  task automatic dispatch(input int rd);
    rob.DPRoB_en = 1'b1;
    rob.DPRoB_rd = EW'(rd);
  endtask

  task automatic cdb(input int idx, input int val);
    rob.CDBRoB_en    = 1'b1;
    rob.CDBRoB_index = RW'(idx);
    rob.CDBRoB_value = 32'(val);
  endtask

  task automatic chk_commit(input string t, input int en, input int idx, input int rd,
                            input int val, input int pj, input int jmp, input int pc);
    chk({t, ".rf_en"}, 32'(rob.RoBRF_en), en);
    chk({t, ".rf_idx"}, 32'(rob.RoBRF_RoB_index), idx);
    chk({t, ".rf_rd"}, 32'(rob.RoBRF_rd), rd);
    chk({t, ".rf_val"}, rob.RoBRF_value, val);
    chk({t, ".pre_judge"}, 32'(rob.RoBRF_pre_judge), pj);
    chk({t, ".jump_en"}, 32'(rob.RoBIF_jump_en), jmp);
    chk({t, ".pc"}, rob.RoBIF_pc, pc);
  endtask

  initial begin
    //          dp_en rd br pr  c_en idx val    tk tgt     en idx rd  val     pj jmp pc    tail
    vt[0]  = '{1, 5,  0, 0,  0, 0, 0,      0, 0,      0, 0, NR, 0,      1, 0, 0,     1};
    vt[1]  = '{0, 0,  0, 0,  1, 0, 'h1234, 0, 0,      0, 0, NR, 0,      1, 0, 0,     1};
    vt[2]  = '{0, 0,  0, 0,  0, 0, 0,      0, 0,      1, 0, 5,  'h1234, 1, 0, 0,     1};
    vt[3]  = '{0, 0,  0, 0,  0, 0, 0,      0, 0,      0, 0, NR, 0,      1, 0, 0,     1};
    vt[4]  = '{1, 1,  0, 0,  0, 0, 0,      0, 0,      0, 0, NR, 0,      1, 0, 0,     2};
    vt[5]  = '{1, 2,  0, 0,  0, 0, 0,      0, 0,      0, 0, NR, 0,      1, 0, 0,     3};
    vt[6]  = '{0, 0,  0, 0,  1, 2, 'hBB,   0, 0,      0, 0, NR, 0,      1, 0, 0,     3};
    vt[7]  = '{0, 0,  0, 0,  0, 0, 0,      0, 0,      0, 0, NR, 0,      1, 0, 0,     3};
    vt[8]  = '{0, 0,  0, 0,  1, 1, 'hAA,   0, 0,      0, 0, NR, 0,      1, 0, 0,     3};
    vt[9]  = '{0, 0,  0, 0,  0, 0, 0,      0, 0,      1, 1, 1,  'hAA,   1, 0, 0,     3};
    vt[10] = '{0, 0,  0, 0,  0, 0, 0,      0, 0,      1, 2, 2,  'hBB,   1, 0, 0,     3};
    vt[11] = '{0, 0,  0, 0,  0, 0, 0,      0, 0,      0, 0, NR, 0,      1, 0, 0,     3};
    vt[12] = '{1, NR, 1, 1,  0, 0, 0,      0, 0,      0, 0, NR, 0,      1, 0, 0,     4};
    vt[13] = '{0, 0,  0, 0,  1, 3, 0,      1, 'h40,   0, 0, NR, 0,      1, 0, 0,     4};
    vt[14] = '{0, 0,  0, 0,  0, 0, 0,      0, 0,      0, 3, NR, 0,      1, 0, 0,     4};
    vt[15] = '{1, 7,  0, 0,  0, 0, 0,      0, 0,      0, 0, NR, 0,      1, 0, 0,     5};
    vt[16] = '{0, 0,  0, 0,  1, 4, 9,      0, 0,      0, 0, NR, 0,      1, 0, 0,     5};
    vt[17] = '{1, 8,  0, 0,  0, 0, 0,      0, 0,      1, 4, 7,  9,      1, 0, 0,     6};
    vt[18] = '{0, 0,  0, 0,  1, 5, 'h55,   0, 0,      0, 0, NR, 0,      1, 0, 0,     6};
    vt[19] = '{0, 0,  0, 0,  0, 0, 0,      0, 0,      1, 5, 8,  'h55,   1, 0, 0,     6};
    vt[20] = '{1, NR, 1, 0,  0, 0, 0,      0, 0,      0, 0, NR, 0,      1, 0, 0,     7};
    vt[21] = '{1, 10, 0, 0,  0, 0, 0,      0, 0,      0, 0, NR, 0,      1, 0, 0,     8};
    vt[22] = '{1, 11, 0, 0,  0, 0, 0,      0, 0,      0, 0, NR, 0,      1, 0, 0,     9};
    vt[23] = '{1, 12, 0, 0,  0, 0, 0,      0, 0,      0, 0, NR, 0,      1, 0, 0,     10};
    vt[24] = '{0, 0,  0, 0,  1, 6, 0,      1, 'h80,   0, 0, NR, 0,      1, 0, 0,     10};
    vt[25] = '{1, 13, 0, 0,  1, 7, 1,      0, 0,      0, 6, NR, 0,      0, 1, 'h80,  0};
    vt[26] = '{0, 0,  0, 0,  1, 0, 5,      0, 0,      0, 0, NR, 0,      1, 0, 0,     0};
    vt[27] = '{0, 0,  0, 0,  0, 0, 0,      0, 0,      0, 0, NR, 0,      1, 0, 0,     0};

    idle();
    Sys_rdy = 1'b1;
    Sys_rst = 1'b1;
    tick();
    tick();
    Sys_rst = 1'b0;
    chk_commit("reset", 0, 0, NR, 0, 1, 0, 0);
    chk("reset.full", 32'(rob.RoBDP_full), 0);
    chk("reset.index", 32'(rob.RoBDP_index), 0);

    for (int i = 0; i < NV; i++) begin
      rob.DPRoB_en        = 1'(vt[i].dp_en);
      rob.DPRoB_rd        = EW'(vt[i].dp_rd);
      rob.DPRoB_is_branch = 1'(vt[i].dp_br);
      rob.DPRoB_pred      = 1'(vt[i].dp_pred);
      rob.CDBRoB_en       = 1'(vt[i].c_en);
      rob.CDBRoB_index    = RW'(vt[i].c_idx);
      rob.CDBRoB_value    = 32'(vt[i].c_val);
      rob.CDBRoB_taken    = 1'(vt[i].c_tk);
      rob.CDBRoB_target   = 32'(vt[i].c_tgt);
      tick();
      chk_commit($sformatf("v%0d", i), vt[i].e_en, vt[i].e_idx, vt[i].e_rd, vt[i].e_val,
                 vt[i].e_pj, vt[i].e_jmp, vt[i].e_pc);
      chk($sformatf("v%0d.tail", i), 32'(rob.RoBDP_index), vt[i].e_tail);
    end
    idle();

    // Lookup forwarding, then a 5-cycle Sys_rdy stall
    Sys_rst = 1'b1;
    tick();
    Sys_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dispatch(i + 1);
      tick();
    end
    idle();
    rob.DPRoB_qidx1 = 3;
    rob.DPRoB_qidx2 = 2;
    cdb(3, 7);
    #1;
    chk("fwd.rdy1", 32'(rob.RoBDP_rdy1), 1);
    chk("fwd.val1", rob.RoBDP_val1, 7);
    chk("fwd.rdy2", 32'(rob.RoBDP_rdy2), 0);
    chk("fwd.val2", rob.RoBDP_val2, 0);
    tick();
    idle();
    rob.DPRoB_qidx1 = 3;
    #1;
    chk("stored.rdy1", 32'(rob.RoBDP_rdy1), 1);
    chk("stored.val1", rob.RoBDP_val1, 7);
    cdb(0, 'h11);
    tick();
    idle();
    Sys_rdy = 1'b0;
    dispatch(9);
    cdb(1, 'h22);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall%0d.tail", i), 32'(rob.RoBDP_index), 4);
      chk($sformatf("stall%0d.rf_en", i), 32'(rob.RoBRF_en), 0);
    end
    Sys_rdy = 1'b1;
    idle();
    rob.DPRoB_qidx1 = 1;
    #1;
    chk("stall.cdb_dropped", 32'(rob.RoBDP_rdy1), 0);
    tick();
    chk_commit("after_stall", 1, 0, 1, 'h11, 1, 0, 0);
    cdb(1, 'h22);
    tick();
    idle();
    chk("head_not_ready.rf_en", 32'(rob.RoBRF_en), 0);
    tick();
    chk_commit("commit1", 1, 1, 2, 'h22, 1, 0, 0);
    Sys_rdy = 1'b0;
    tick();
    chk("stall_pulse.rf_en", 32'(rob.RoBRF_en), 0);
    chk("stall_pulse.pj", 32'(rob.RoBRF_pre_judge), 1);
    Sys_rdy = 1'b1;

    // Reset mid-stream discards the two remaining entries
    Sys_rst = 1'b1;
    tick();
    Sys_rst = 1'b0;
    chk("midrst.index", 32'(rob.RoBDP_index), 0);
    cdb(0, 'h5);
    tick();
    idle();
    tick();
    chk("midrst.rf_en", 32'(rob.RoBRF_en), 0);

    // Fill, refuse while full, commit head, wrap tail to index 0
    for (int i = 0; i < SZ; i++) begin
      dispatch(i % 32);
      tick();
    end
    chk("full.full", 32'(rob.RoBDP_full), 1);
    chk("full.index", 32'(rob.RoBDP_index), 0);
    dispatch(33);
    tick();
    chk("full_refuse.full", 32'(rob.RoBDP_full), 1);
    cdb(0, 'hF0);
    tick();
    rob.CDBRoB_en = 1'b0;
    chk("full_cdb.rf_en", 32'(rob.RoBRF_en), 0);
    tick();
    chk_commit("full_commit", 1, 0, 0, 'hF0, 1, 0, 0);
    chk("full_commit.full", 32'(rob.RoBDP_full), 0);
    chk("full_commit.index", 32'(rob.RoBDP_index), 0);
    dispatch(3);
    tick();
    idle();
    chk("wrap.index", 32'(rob.RoBDP_index), 1);
    chk("wrap.full", 32'(rob.RoBDP_full), 1);
    Sys_rst = 1'b1;
    tick();
    Sys_rst = 1'b0;
    chk("final_rst.full", 32'(rob.RoBDP_full), 0);
    chk("final_rst.index", 32'(rob.RoBDP_index), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
